// File: rtl/dfe_pkg.sv
// Shared DFE definitions: sample format, CIC accumulator sizing and
// saturation limits used by the decimation chain.
package dfe_pkg;

    localparam int DFE_DATA_WIDTH = 16;
    localparam int DFE_DATA_FRAC  = 15;

    function automatic int acc_width(input int dw, input int ns, input int lr);
        return dw + ns * lr;
    endfunction

    function automatic longint sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // Ratio selects above the supported maximum behave as the maximum.
    function automatic logic [2:0] clamp_sel(input logic [2:0] sel, input int lr);
        logic [2:0] res;
        if (int'({29'd0, sel}) > lr) begin
            res = 3'(lr);
        end else begin
            res = sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y = x - x(previous decimated sample).
module cic_comb_stage #(
    parameter int ACC_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_x,
    output logic [ACC_W-1:0] o_y
);

    logic [ACC_W-1:0] r_dly;

    assign o_y = i_x - r_dly;

    // Delay element, updated once per decimated sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly <= {ACC_W{1'b0}};
        end else if (i_clr) begin
            r_dly <= {ACC_W{1'b0}};
        end else if (i_en) begin
            r_dly <= i_x;
        end else begin
            r_dly <= r_dly;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Integer CIC decimator, R = 2^dec_sel, with rounding normalisation and
// output saturation. Integrators are inline; combs are cic_comb_stage.
module cic_decimator
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH = DFE_DATA_WIDTH,
    parameter int DATA_FRAC  = DFE_DATA_FRAC,
    parameter int N_STAGE    = 3,
    parameter int LOG2_RMAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] filter_in,
    input  logic [2:0]            dec_sel,
    output logic [DATA_WIDTH-1:0] filter_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ACC_W = acc_width(DATA_WIDTH, N_STAGE, LOG2_RMAX);
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(DATA_WIDTH));
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(DATA_WIDTH));

    logic                   r_loaded;
    logic [2:0]             r_dec_sel;
    logic                   w_flush;
    logic [2:0]             w_sel;
    logic [LOG2_RMAX-1:0]   w_last;
    logic [LOG2_RMAX-1:0]   r_phase;
    logic                   w_wrap;
    logic [7:0]             w_shift;

    logic [ACC_W-1:0]       w_in_ext;
    logic [ACC_W-1:0]       r_int     [N_STAGE];
    logic [ACC_W-1:0]       w_int_nxt [N_STAGE];
    logic [ACC_W-1:0]       w_comb    [N_STAGE+1];

    logic                   r_wrap_d;
    logic                   r_comb_vld;
    logic [ACC_W-1:0]       r_comb_out;

    logic signed [EXT_W-1:0] w_rnd;
    logic signed [EXT_W-1:0] w_scaled;
    logic [DATA_WIDTH-1:0]   w_sat;
    logic                    w_ovf;
    logic                    w_unf;

    // Ratio selection, flush detection and frame-wrap decode.
    always_comb begin
        w_flush = 1'b0;
        w_sel   = clamp_sel(dec_sel, LOG2_RMAX);
        if (r_loaded) begin
            w_flush = (dec_sel != r_dec_sel);
            w_sel   = clamp_sel(r_dec_sel, LOG2_RMAX);
        end else begin
            w_flush = 1'b0;
            w_sel   = clamp_sel(dec_sel, LOG2_RMAX);
        end
        w_last  = ~({LOG2_RMAX{1'b1}} << w_sel);
        w_wrap  = valid_in && !w_flush && (r_phase == w_last);
        w_shift = 8'(N_STAGE * int'({29'd0, w_sel}));
    end

    // Ratio register; the first edge after reset only loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loaded  <= 1'b0;
            r_dec_sel <= 3'd0;
        end else begin
            r_loaded  <= 1'b1;
            r_dec_sel <= dec_sel;
        end
    end

    // Integrator chain evaluated in one cycle so all stages see this sample.
    always_comb begin
        w_in_ext = {{(ACC_W-DATA_WIDTH){filter_in[DATA_WIDTH-1]}}, filter_in};
        for (int k = 0; k < N_STAGE; k++) begin
            if (k == 0) begin
                w_int_nxt[k] = r_int[k] + w_in_ext;
            end else begin
                w_int_nxt[k] = r_int[k] + w_int_nxt[k-1];
            end
        end
    end

    // Integrator state and phase counter; frozen when valid_in is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_STAGE; k++) begin
                r_int[k] <= {ACC_W{1'b0}};
            end
            r_phase  <= {LOG2_RMAX{1'b0}};
            r_wrap_d <= 1'b0;
        end else if (w_flush) begin
            for (int k = 0; k < N_STAGE; k++) begin
                r_int[k] <= {ACC_W{1'b0}};
            end
            r_phase  <= {LOG2_RMAX{1'b0}};
            r_wrap_d <= 1'b0;
        end else if (valid_in) begin
            for (int k = 0; k < N_STAGE; k++) begin
                r_int[k] <= w_int_nxt[k];
            end
            r_phase  <= w_wrap ? {LOG2_RMAX{1'b0}} : r_phase + LOG2_RMAX'(1);
            r_wrap_d <= w_wrap;
        end else begin
            r_wrap_d <= 1'b0;
        end
    end

    assign w_comb[0] = r_int[N_STAGE-1];

    for (genvar g = 0; g < N_STAGE; g++) begin : g_comb
        cic_comb_stage #(
            .ACC_W (ACC_W)
        ) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (w_flush),
            .i_en  (r_wrap_d),
            .i_x   (w_comb[g]),
            .o_y   (w_comb[g+1])
        );
    end

    // Capture the comb result of the decimated sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_comb_out <= {ACC_W{1'b0}};
            r_comb_vld <= 1'b0;
        end else if (w_flush) begin
            r_comb_vld <= 1'b0;
        end else begin
            r_comb_vld <= r_wrap_d;
            if (r_wrap_d) begin
                r_comb_out <= w_comb[N_STAGE];
            end else begin
                r_comb_out <= r_comb_out;
            end
        end
    end

    // Remove the R^N gain with round-half-up, then clip to the sample range.
    always_comb begin
        w_rnd = {r_comb_out[ACC_W-1], r_comb_out};
        if (w_shift != 8'd0) begin
            w_rnd = w_rnd + ({{(EXT_W-1){1'b0}}, 1'b1} << (w_shift - 8'd1));
        end else begin
            w_rnd = w_rnd;
        end
        w_scaled = w_rnd >>> w_shift;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_sat    = w_scaled[DATA_WIDTH-1:0];
        if (w_scaled > SAT_HI) begin
            w_ovf = 1'b1;
            w_sat = SAT_HI[DATA_WIDTH-1:0];
        end else if (w_scaled < SAT_LO) begin
            w_unf = 1'b1;
            w_sat = SAT_LO[DATA_WIDTH-1:0];
        end else begin
            w_sat = w_scaled[DATA_WIDTH-1:0];
        end
    end

    // Output register; a flush drops any result still in the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_out <= {DATA_WIDTH{1'b0}};
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (w_flush) begin
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (r_comb_vld) begin
            filter_out <= w_sat;
            valid_out  <= 1'b1;
            overflow   <= w_ovf;
            underflow  <= w_unf;
        end else begin
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end
    end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter DATA_FRAC, default 15, fractional bits of input and output samples (Q1.15).
REQ-003 SHALL have parameter N_STAGE, default 3, number of integrator/comb stage pairs.
REQ-004 SHALL have parameter LOG2_RMAX, default 4, log2 of the maximum decimation ratio (16).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port valid_in, input, 1, filter_in carries a sample this cycle (the fractional decimator's valid_out).
REQ-008 SHALL have port filter_in, input, DATA_WIDTH, signed input sample (the fractional decimator's filter_out).
REQ-009 SHALL have port dec_sel, input, 3, decimation ratio R = 2^dec_sel; legal values 0..LOG2_RMAX; R=1 is bypass.
REQ-010 SHALL have port filter_out, output, DATA_WIDTH, signed decimated sample.
REQ-011 SHALL have port valid_out, output, 1, one-cycle strobe qualifying filter_out.
REQ-012 SHALL have port overflow, output, 1, output saturated positive on this valid_out.
REQ-013 SHALL have port underflow, output, 1, output saturated negative on this valid_out.

Function
REQ-014 SHALL use an internal accumulator width of DATA_WIDTH + N_STAGE*LOG2_RMAX bits (28 at defaults), with wrap-around two's-complement arithmetic in the integrators.
REQ-015 SHALL update the integrators only in cycles with valid_in=1; gaps in valid_in SHALL leave all state frozen.
REQ-016 SHALL use a phase counter 0..R-1 that advances on each valid_in and wraps at R-1; the comb chain SHALL update only on the valid_in at the wrap.
REQ-017 SHALL normalise the comb output by an arithmetic right shift of N_STAGE*dec_sel bits with round-half-up, then saturate to DATA_WIDTH.
REQ-018 SHALL raise overflow or underflow only in the cycle of the saturated valid_out, and SHALL clear both otherwise.
REQ-019 SHALL assert valid_out exactly 2 cycles after the clock edge sampling the wrap-phase valid_in, for 1 cycle; filter_out SHALL hold its value until the next valid_out.
REQ-020 SHALL, in bypass (dec_sel=0), register filter_in to filter_out with the same 2-cycle latency and SHALL assert valid_out for every valid_in.
REQ-021 SHALL latch dec_sel into an internal ratio register; any change in dec_sel SHALL clear the integrators, combs and phase counter on the next edge, discard the in-flight output, and apply the new ratio from the following valid_in.
REQ-022 SHALL treat dec_sel greater than LOG2_RMAX as LOG2_RMAX.
REQ-023 SHALL ignore valid_in in the cycle a flush (REQ-021) is taking place.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear integrators, combs, phase counter and pipeline registers, and set filter_out=0, valid_out=0, overflow=0, underflow=0.
REQ-025 SHALL, on reset mid-frame, discard any partial decimation frame; after release, the first output SHALL need R fresh valid_in samples.
REQ-026 SHALL load the ratio register from dec_sel on the first clock edge after reset release, without triggering a flush.

Structure
REQ-027 SHALL take DATA_WIDTH, DATA_FRAC, the accumulator-width function and the saturation limits from the shared DFE package dfe_pkg.
REQ-028 SHALL implement one comb stage as sub-module cic_comb_stage, instantiated N_STAGE times; the integrators SHALL remain inline.

Verification
REQ-029 SHALL verify DC steady state: dec_sel=2, filter_in=16384 continuous -> after the settling frames, filter_out=16384 on every valid_out, with one valid_out per 4 valid_in.
REQ-030 SHALL verify the full-scale limit: dec_sel=4, filter_in=32767 constant -> filter_out settles to 32767, with overflow=0 throughout.
REQ-031 SHALL verify throttled input: dec_sel=3, valid_in at 1-in-3 duty, DC 8192 -> filter_out=8192, with exactly one valid_out per 8 valid_in and a 2-cycle latency.
REQ-032 SHALL verify bypass: dec_sel=0, ramp -32768..32767 -> filter_out equals filter_in delayed 2 cycles, with valid_out mirroring valid_in.
REQ-033 SHALL verify the ratio change: switch dec_sel from 2 to 1 mid-frame -> no valid_out for the aborted frame, and the next output appears after exactly 2 new valid_in.
REQ-034 SHALL verify reset mid-frame: rst_n low for 3 cycles after 5 of 8 samples -> all outputs 0 immediately, and the first post-reset valid_out follows 8 new valid_in.
